bram_interface: RTL and testbench

//  Single-port block-RAM wrapper with fixed multi-cycle read latency and two access modes.

---
 rtl/bram_interface.sv | 102 ++++++++++
 tb/tb_bram_interface.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_interface.sv
// Single-port block-RAM wrapper with a fixed read latency. It supports random-access
// reads and writes, plus a sequential streaming mode with a next/valid handshake.
`ifndef WD_DATA_WIDTH
`define WD_DATA_WIDTH 16
`endif

module bram_interface #(
   parameter int DATA_WIDTH = `WD_DATA_WIDTH,
   parameter int BRAM_DEPTH = 500,
   parameter int BRAM_DELAY = 3,
   localparam int AW = $clog2(BRAM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [AW-1:0]         addr,
   input  logic [DATA_WIDTH-1:0] line_in,
   input  logic                  we,
   input  logic                  en,
   input  logic                  generator_mode,
   input  logic                  rst_gen_mode,
   input  logic                  next,
   output logic [DATA_WIDTH-1:0] line_out,
   output logic                  valid_line_out,
   output logic [AW-1:0]         generator_addr,
   output logic                  write_rdy
);

   logic [DATA_WIDTH-1:0] mem [BRAM_DEPTH];
   logic [DATA_WIDTH-1:0] data_pipe [BRAM_DELAY];
   logic [BRAM_DELAY-1:0] vld_pipe;
   logic [BRAM_DELAY-1:0] gen_pipe;
   logic                  gen_mode_q;
   logic                  out_is_gen;

   logic          gen_rise, gen_fall, kill_gen, kill_norm;
   logic          addr_ok, consume, gen_fetch, norm_read, wr_en, arrive;
   logic [AW-1:0] next_gen_addr, fetch_addr, rd_addr;

   // NOTE: every signal is assigned on every path, so no latch can be inferred.
   always_comb begin
      gen_rise      = generator_mode & ~gen_mode_q;
      gen_fall      = ~generator_mode & gen_mode_q;
      kill_gen      = rst_gen_mode | gen_fall;
      kill_norm     = gen_rise;
      addr_ok       = 32'(addr) < 32'(BRAM_DEPTH);
      consume       = generator_mode & next & valid_line_out & out_is_gen & ~rst_gen_mode;
      next_gen_addr = (32'(generator_addr) == 32'(BRAM_DEPTH - 1)) ? '0 : generator_addr + AW'(1);
      fetch_addr    = rst_gen_mode ? '0 : (consume ? next_gen_addr : generator_addr);
      gen_fetch     = generator_mode & (gen_rise | rst_gen_mode | consume);
      norm_read     = ~generator_mode & en & ~we & addr_ok;
      wr_en         = ~generator_mode & en & we & write_rdy & addr_ok;
      rd_addr       = gen_fetch ? fetch_addr : (addr_ok ? addr : '0);
      arrive        = vld_pipe[BRAM_DELAY-1] &
                      ~(gen_pipe[BRAM_DELAY-1] ? kill_gen : kill_norm);
   end

   // NOTE: the array and data stages have no reset; only the valid flags must be cleared.
   always_ff @(posedge clk) begin
      if (wr_en) mem[addr] <= line_in;
      data_pipe[0] <= mem[rd_addr];
      for (int i = 1; i < BRAM_DELAY; i++) data_pipe[i] <= data_pipe[i-1];
   end

   // NOTE: non-blocking assignments keep every stage sampling pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gen_mode_q     <= 1'b0;
         write_rdy      <= 1'b0;
         generator_addr <= '0;
         vld_pipe       <= '0;
         gen_pipe       <= '0;
         line_out       <= '0;
         valid_line_out <= 1'b0;
         out_is_gen     <= 1'b0;
      end else begin
         gen_mode_q <= generator_mode;
         write_rdy  <= ~generator_mode;

         if (rst_gen_mode)  generator_addr <= '0;
         else if (consume)  generator_addr <= next_gen_addr;

         // Each in-flight entry carries its origin, so a mode change discards only its own kind.
         vld_pipe[0] <= gen_fetch | norm_read;
         gen_pipe[0] <= gen_fetch;
         for (int i = 1; i < BRAM_DELAY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1] & ~(gen_pipe[i-1] ? kill_gen : kill_norm);
            gen_pipe[i] <= gen_pipe[i-1];
         end

         if (arrive) begin
            line_out       <= data_pipe[BRAM_DELAY-1];
            valid_line_out <= 1'b1;
            out_is_gen     <= gen_pipe[BRAM_DELAY-1];
         end else begin
            // A streamed line stays valid until consumed; normal results are single pulses.
            valid_line_out <= valid_line_out & out_is_gen & generator_mode &
                              ~consume & ~rst_gen_mode;
         end
      end
   end

endmodule

// File: tb/tb_bram_interface.sv
// Directed bench for bram_interface: normal reads and writes, streaming, wrap,
// stream restart and asynchronous reset.
module tb_bram_interface;

   localparam int DW    = 16;
   localparam int DEPTH = 500;
   localparam int AW    = 9;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] addr;
   logic [DW-1:0] line_in;
   logic          we, en, generator_mode, rst_gen_mode, next;
   logic [DW-1:0] line_out;
   logic          valid_line_out;
   logic [AW-1:0] generator_addr;
   logic          write_rdy;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [DW-1:0] model [DEPTH];
   logic [DW-1:0] v;

   bram_interface #(.DATA_WIDTH(DW), .BRAM_DEPTH(DEPTH), .BRAM_DELAY(3)) dut (
      .clk(clk), .rst(rst), .addr(addr), .line_in(line_in), .we(we), .en(en),
      .generator_mode(generator_mode), .rst_gen_mode(rst_gen_mode), .next(next),
      .line_out(line_out), .valid_line_out(valid_line_out),
      .generator_addr(generator_addr), .write_rdy(write_rdy)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_write(input int a, input logic [DW-1:0] d);
      en = 1'b1; we = 1'b1; addr = AW'(a); line_in = d;
      @(negedge clk);
      en = 1'b0; we = 1'b0;
      model[a] = d;
   endtask

   task automatic wait_valid(output int cycles);
      cycles = 0;
      while (valid_line_out !== 1'b1 && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic pulse_next();
      next = 1'b1;
      @(negedge clk);
      next = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 0; we = 0; addr = '0; line_in = '0;
      generator_mode = 0; rst_gen_mode = 0; next = 0;
      #12;
      n_cmp++;
      if ({line_out, valid_line_out, generator_addr, write_rdy} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h/%b/%0d/%b want 0/0/0/0",
                  line_out, valid_line_out, generator_addr, write_rdy);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if (write_rdy !== 1'b0) begin
         n_err++; $display("FAIL write_rdy_before_edge: got %b want 0", write_rdy);
      end
      @(negedge clk);
      n_cmp++;
      if (write_rdy !== 1'b1) begin
         n_err++; $display("FAIL write_rdy_after_edge: got %b want 1", write_rdy);
      end
   endtask

   task automatic test_write_read();
      v = DW'($urandom_range(0, 200) - 100);
      do_write(2, v);
      en = 1'b1; we = 1'b0; addr = 9'd2;
      for (int c = 0; c <= 4; c++) begin
         @(negedge clk);
         en = 1'b0;
         n_cmp++;
         if (valid_line_out !== (c == 3)) begin
            n_err++; $display("FAIL read_valid c=%0d: got %b want %b", c, valid_line_out, c == 3);
         end
         if (c >= 3) begin
            n_cmp++;
            if (line_out !== v) begin
               n_err++; $display("FAIL read_data c=%0d: got %h want %h", c, line_out, v);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 10; n++) do_write(n, DW'(n));
      en = 1'b1; we = 1'b0; addr = '0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         n_cmp++;
         if (valid_line_out !== (c >= 3 && c <= 12)) begin
            n_err++; $display("FAIL b2b_valid c=%0d: got %b", c, valid_line_out);
         end
         if (c >= 3 && c <= 12) begin
            n_cmp++;
            if (line_out !== DW'(c - 3)) begin
               n_err++; $display("FAIL b2b_data c=%0d: got %h want %h", c, line_out, DW'(c - 3));
            end
         end
         if (c < 9) addr = AW'(c + 1);
         else en = 1'b0;
      end
   endtask

   task automatic fill_memory();
      for (int n = 10; n < DEPTH; n++) do_write(n, DW'(n) ^ 16'hA5A5);
      do_write(2, v);
   endtask

   task automatic test_generator();
      int cyc;
      en = 1'b1; we = 1'b1; addr = '0; line_in = 16'hDEAD;
      generator_mode = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (write_rdy !== 1'b0) begin
         n_err++; $display("FAIL gen_write_rdy: got %b want 0", write_rdy);
      end
      for (int n = 0; n < 5; n++) begin
         wait_valid(cyc);
         n_cmp++;
         if (cyc != 3 || line_out !== model[n] || generator_addr !== AW'(n)) begin
            n_err++;
            $display("FAIL gen_line n=%0d: lat %0d data %h addr %0d want lat 3 data %h addr %0d",
                     n, cyc, line_out, generator_addr, model[n], n);
         end
         pulse_next();
         n_cmp++;
         if (valid_line_out !== 1'b0 || generator_addr !== AW'(n + 1)) begin
            n_err++;
            $display("FAIL gen_consume n=%0d: valid %b addr %0d want 0 and %0d",
                     n, valid_line_out, generator_addr, n + 1);
         end
      end
   endtask

   task automatic test_wrap();
      int cyc;
      for (int n = 5; n < DEPTH; n++) begin
         wait_valid(cyc);
         n_cmp++;
         if (cyc >= 20 || line_out !== model[n]) begin
            n_err++;
            $display("FAIL stream_line n=%0d: lat %0d data %h want %h", n, cyc, line_out, model[n]);
            return;
         end
         if (n < DEPTH - 1) pulse_next();
      end
      n_cmp++;
      if (generator_addr !== AW'(DEPTH - 1)) begin
         n_err++; $display("FAIL wrap_last_addr: got %0d want %0d", generator_addr, DEPTH - 1);
      end
      pulse_next();
      n_cmp++;
      if (generator_addr !== '0) begin
         n_err++; $display("FAIL wrap_addr: got %0d want 0", generator_addr);
      end
      wait_valid(cyc);
      n_cmp++;
      if (cyc != 3 || line_out !== model[0]) begin
         n_err++; $display("FAIL wrap_data: lat %0d data %h want lat 3 data %h", cyc, line_out, model[0]);
      end
   endtask

   task automatic test_restart();
      int cyc;
      for (int k = 0; k < 5; k++) begin
         pulse_next();
         wait_valid(cyc);
      end
      n_cmp++;
      if (generator_addr !== 9'd5 || line_out !== model[5] || valid_line_out !== 1'b1) begin
         n_err++; $display("FAIL restart_pre: addr %0d data %h want 5 and %h", generator_addr, line_out, model[5]);
      end
      rst_gen_mode = 1'b1; next = 1'b1;
      @(negedge clk);
      rst_gen_mode = 1'b0; next = 1'b0;
      for (int c = 0; c <= 3; c++) begin
         if (c > 0) @(negedge clk);
         n_cmp++;
         if (valid_line_out !== (c == 3) || generator_addr !== '0) begin
            n_err++;
            $display("FAIL restart c=%0d: valid %b addr %0d want %b and 0", c, valid_line_out, generator_addr, c == 3);
         end
      end
      n_cmp++;
      if (line_out !== model[0]) begin
         n_err++; $display("FAIL restart_data: got %h want %h", line_out, model[0]);
      end
      en = 1'b0; we = 1'b0;
   endtask

   task automatic test_async_reset();
      int cyc;
      for (int k = 0; k < 3; k++) begin
         pulse_next();
         wait_valid(cyc);
      end
      n_cmp++;
      if (generator_addr !== 9'd3 || line_out !== model[3]) begin
         n_err++; $display("FAIL prereset_state: addr %0d data %h want 3 and %h", generator_addr, line_out, model[3]);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({line_out, valid_line_out, generator_addr, write_rdy} !== '0) begin
         n_err++;
         $display("FAIL midstream_reset: got %h/%b/%0d/%b want 0/0/0/0",
                  line_out, valid_line_out, generator_addr, write_rdy);
      end
      generator_mode = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      en = 1'b1; we = 1'b0; addr = 9'd2;
      for (int c = 0; c <= 3; c++) begin
         @(negedge clk);
         en = 1'b0;
         n_cmp++;
         if (valid_line_out !== (c == 3)) begin
            n_err++; $display("FAIL post_reset_valid c=%0d: got %b want %b", c, valid_line_out, c == 3);
         end
      end
      n_cmp++;
      if (line_out !== v) begin
         n_err++; $display("FAIL post_reset_data: got %h want %h", line_out, v);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      fill_memory();
      test_generator();
      test_wrap();
      test_restart();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
